dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline memory stage (port P) and a loader/debug DMA engine (port D).
- Pipeline has priority. A starvation counter forces a DMA grant after a bounded wait.
- When D takes the memory while P is requesting, the block raises a stall to the pipeline.
- Sits between the memory stage and the dmem instance. It drives the memory's we/a/wd and receives its asynchronous rd.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the pipeline (P) and DMA (D).
// Ports: clk/reset; p_* pipeline side; d_* DMA side; mem_* to the dmem instance.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    PIPE,
    DMA
  } sel_t;

  sel_t          sel;
  sel_t          selNext;
  logic [CW-1:0] starve;
  logic [CW-1:0] starveNext;
  logic          forceD;
  logic          grantD;
  logic          grantP;

  // D is never force-granted twice in a row over a requesting P.
  always_comb begin
    forceD = d_req & (starve >= CW'(STARVE_MAX));
    grantD = d_req & (!p_req | forceD);
    if (forceD & p_req & (sel == DMA))
      grantD = 1'b0;
    grantP = p_req & !grantD;
  end

  always_comb begin
    selNext = IDLE;
    unique case (1'b1)
      grantD:  selNext = DMA;
      grantP:  selNext = PIPE;
      default: selNext = IDLE;
    endcase
  end

  always_comb begin
    starveNext = '0;
    if (d_req & !grantD)
      starveNext = (starve == '1) ? starve
                 : starve + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel    <= IDLE;
      starve <= '0;
    end else begin
      sel    <= selNext;
      starve <= starveNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rdata  <= '0;
      d_rvalid <= 1'b0;
    end else if (grantD & !d_we) begin
      d_rdata  <= mem_rd;
      d_rvalid <= 1'b1;
    end else begin
      d_rvalid <= 1'b0;
    end
  end

  // Idle cycles present the pipeline address so its
  // async read path needs no extra mux select.
  always_comb begin
    mem_a   = grantD ? d_addr  : p_addr;
    mem_wd  = grantD ? d_wdata : p_wdata;
    mem_we  = 1'b0;
    if (!reset)
      mem_we = grantD ? d_we : (grantP & p_we);
  end

  assign p_rdata = mem_rd;
  assign d_gnt   = !reset & grantD;
  assign p_stall = !reset & p_req & grantD;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with a
// 64-word async-read memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_stall;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_gnt, d_rvalid;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4), .CW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_stall  (p_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always @(posedge clk)
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic pr, input logic pw,
                     input logic [31:0] pa, input logic [31:0] pd,
                     input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd);
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1;
    drv(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'hBAD0BAD0);

    // reset forces outputs even with a live D write request
    @(negedge clk); #2;
    check("rst_mem_we_d", mem_we, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_d_rdata", d_rdata, 0);
    drv(1, 1, 32'h24, 32'hBAD1BAD1, 1, 0, 32'h20, 32'h0);
    #1;
    check("rst_mem_we_p", mem_we, 0);
    check("rst_p_stall", p_stall, 0);
    @(posedge clk); #1;
    check("rst_no_write", mem[8], 0);

    // idle
    @(negedge clk);
    reset = 1'b0;
    drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    #2;
    check("idle_mem_we", mem_we, 0);
    check("idle_p_stall", p_stall, 0);
    check("idle_d_gnt", d_gnt, 0);

    // P store then P load
    @(negedge clk);
    drv(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    #2;
    check("pst_mem_we", mem_we, 1);
    check("pst_mem_a", mem_a, 32'h10);
    check("pst_mem_wd", mem_wd, 32'hDEADBEEF);
    check("pst_p_stall", p_stall, 0);
    @(negedge clk);
    drv(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    #2;
    check("pld_p_rdata", p_rdata, 32'hDEADBEEF);
    check("pld_mem_we", mem_we, 0);
    check("pld_p_stall", p_stall, 0);

    // D write then D read
    @(negedge clk);
    drv(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    #2;
    check("dwr_d_gnt", d_gnt, 1);
    check("dwr_mem_we", mem_we, 1);
    check("dwr_mem_a", mem_a, 32'h20);
    @(negedge clk);
    drv(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    #2;
    check("drd_d_gnt", d_gnt, 1);
    check("drd_mem_we", mem_we, 0);
    check("drd_rvalid_early", d_rvalid, 0);
    @(posedge clk); #1;
    check("drd_rvalid", d_rvalid, 1);
    check("drd_rdata", d_rdata, 32'h12345678);
    @(negedge clk);
    drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("drd_rvalid_pulse", d_rvalid, 0);
    check("drd_rdata_hold", d_rdata, 32'h12345678);

    // both held: D forced every 5th cycle; k=12 has starve=2
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drv(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
      #2;
      check($sformatf("stv%0d_d_gnt", k), d_gnt, (k % 5) == 4);
      check($sformatf("stv%0d_p_stall", k), p_stall, (k % 5) == 4);
      check($sformatf("stv%0d_mem_a", k), mem_a,
            ((k % 5) == 4) ? 32'h20 : 32'h10);
      check($sformatf("stv%0d_rvalid", k), d_rvalid,
            (k > 0) && ((k % 5) == 0));
      if ((k % 5) != 4)
        check($sformatf("stv%0d_p_rdata", k), p_rdata, 32'hDEADBEEF);
    end

    // D dropping its request clears the starvation count
    @(negedge clk);
    drv(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    drv(1, 0, 32'h10, 32'h0, 0, 0, 32'h20, 32'h0);
    #2;
    check("drop_d_gnt", d_gnt, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drv(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
      #2;
      check($sformatf("drop%0d_d_gnt", k), d_gnt, k == 4);
    end

    // reset during a granted D read
    @(negedge clk);
    drv(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    #2;
    check("mid_d_gnt", d_gnt, 1);
    reset = 1'b1;
    #1;
    check("mid_d_gnt_rst", d_gnt, 0);
    @(posedge clk); #1;
    check("mid_rvalid", d_rvalid, 0);
    check("mid_rdata", d_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drv(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
      #2;
      check($sformatf("post%0d_d_gnt", k), d_gnt, k == 4);
    end
    @(posedge clk); #1;
    check("post_rvalid", d_rvalid, 1);
    check("post_rdata", d_rdata, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
